// File: rtl/bram_sdp_arb.sv
// bram_sdp_arb: zero-fill sequencer and round-robin read arbiter in front of a
// simple-dual-port block RAM with 1- or 2-cycle read latency.
module bram_sdp_arb #(
    parameter int ADR = 8,
    parameter int DAT = 9,
    parameter int DEP = 256,
    parameter int DEL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init_req,
    output logic           init_done,
    input  logic           cwen,
    input  logic [ADR-1:0] cwad,
    input  logic [DAT-1:0] cwda,
    output logic           cwrdy,
    input  logic           r0req,
    input  logic [ADR-1:0] r0ad,
    output logic           r0ack,
    output logic           r0vld,
    input  logic           r1req,
    input  logic [ADR-1:0] r1ad,
    output logic           r1ack,
    output logic           r1vld,
    output logic [DAT-1:0] rdo,
    output logic           wen,
    output logic [ADR-1:0] wad,
    output logic [DAT-1:0] wda,
    output logic           ren,
    output logic [ADR-1:0] rad,
    input  logic [DAT-1:0] rda
);
    typedef enum logic {INIT, RUN} state_t;
    state_t st;
    logic [ADR-1:0] cnt;
    logic last, run, g0, g1;
    logic [DEL-1:0] vp, ip;
    assign run = st == RUN;
    // last=1 means requester 1 was granted most recently, so requester 0 wins a tie
    assign g0 = run & r0req & (~r1req | last);
    assign g1 = run & r1req & (~r0req | ~last);
    assign r0ack = g0;
    assign r1ack = g1;
    assign ren = g0 | g1;
    assign rad = g0 ? r0ad : g1 ? r1ad : '0;
    assign wen = run ? cwen : 1'b1;
    assign wad = run ? cwad : cnt;
    assign wda = run ? cwda : '0;
    assign cwrdy = init_done;
    assign rdo = rda;
    assign r0vld = vp[DEL-1] & ~ip[DEL-1];
    assign r1vld = vp[DEL-1] & ip[DEL-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= INIT;
            cnt <= '0;
            init_done <= 1'b0;
            last <= 1'b1;
            vp <= '0;
            ip <= '0;
        end else begin
            // return pipeline of {valid, id}; keeps shifting through INIT
            vp <= DEL'({vp, ren});
            ip <= DEL'({ip, g1});
            if (ren) last <= g1;
            if (init_req) begin
                st <= INIT;
                init_done <= 1'b0;
                cnt <= '0;
            end else if (!run) begin
                if (cnt == ADR'(DEP - 1)) begin
                    st <= RUN;
                    init_done <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/bram_sdp_arb.md
Name: bram_sdp_arb

Overview:
- Single-clock sequencer and arbiter in front of one simple-dual-port block RAM: 8-bit address, 9-bit data, 256 deep, read latency 1 or 2. The RAM's write and read clocks are both tied to clk.
- After reset, and on request, it zero-fills the RAM.
- After the fill it passes one writer straight through and shares the read port between two requesters, round-robin, with req/ack handshakes and a per-requester valid on the returned data.

Parameters:
- ADR, 8, address width.
- DAT, 9, data width.
- DEP, 256, RAM depth; init walks addresses 0..DEP-1.
- DEL, 1, RAM read latency in clk cycles (1 or 2); must equal the RAM's latency setting.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- init_req  in  1  one-cycle pulse; restarts the zero-fill.
- init_done  out  1  high once the fill completes.
- cwen  in  1  client write strobe.
- cwad  in  ADR  client write address.
- cwda  in  DAT  client write data.
- cwrdy  out  1  client write accepted; equals init_done.
- r0req  in  1  requester 0 read request.
- r0ad  in  ADR  requester 0 read address.
- r0ack  out  1  requester 0 grant.
- r0vld  out  1  requester 0 data valid.
- r1req  in  1  requester 1 read request.
- r1ad  in  ADR  requester 1 read address.
- r1ack  out  1  requester 1 grant.
- r1vld  out  1  requester 1 data valid.
- rdo  out  DAT  read data, shared by both requesters.
- wen  out  1  RAM write enable.
- wad  out  ADR  RAM write address.
- wda  out  DAT  RAM write data.
- ren  out  1  RAM read enable.
- rad  out  ADR  RAM read address.
- rda  in  DAT  RAM read data. The RAM's rrst is tied low.

Behaviour:
- Reset values: init_done=0, cwrdy=0, r0ack=r1ack=0, r0vld=r1vld=0, init counter=0, round-robin last-grant=1 (requester 0 wins first), valid pipeline cleared. On rst release the FSM is in INIT.
- FSM has two states, INIT and RUN.
  - INIT: every cycle wen=1, wad=cnt, wda=0; cnt increments. The cycle with cnt==DEP-1 writes the last word; next cycle the FSM is in RUN and init_done=1.
  - INIT lasts exactly DEP cycles.
  - During INIT, cwen is ignored (cwrdy=0) and no reads are granted.
- RUN: wen=cwen, wad=cwad, wda=cwda; these are combinational pass-through.
- init_req in RUN: next cycle the FSM is in INIT with cnt=0 and init_done=0.
- init_req during INIT: cnt restarts at 0.
- Read arbitration, RUN only, at most one grant per cycle:
  - Only one requester asserting: it is granted.
  - Both asserting: grant the one not granted last.
  - last-grant updates only on a grant.
  - ack is combinational in the same cycle as req. On grant: ren=1, rad = the granted address. Otherwise ren=0, rad=0.
- Requesters hold req and address stable until ack. A requester may hold req high to stream; it is granted every cycle when alone and every other cycle when contending.
- Return path:
  - rXvld is asserted exactly DEL cycles after the ack cycle, for one cycle, for the granted requester only.
  - rdo = rda, combinational.
  - Implementation is a DEL-deep shift register of {valid, id}.
  - Back-to-back grants produce back-to-back valids in order.
- The return pipeline keeps shifting in INIT, so reads granted before an init_req still deliver their valids. Their data is the pre-init contents, because a read and a write in the same cycle return old data.
- Same-address write and read in the same cycle: the read returns the old word (read-first). The new word is seen by a read granted one or more cycles later.
- Address wrap: the init counter is ADR bits wide, compared to DEP-1, and never exceeds DEP-1.
- Async rst mid-operation: all state returns to reset values immediately, and in-flight valids are dropped. RAM contents are undefined until the fresh INIT completes.

Test Plan:
- Reset, then idle → wen=1 for 256 consecutive cycles with wad 0..255 and wda=0; init_done rises on cycle 256. Reads of addresses 0, 128 and 255 then return 0.
- RUN, DEL=1, write 0x1A5 at address 0x10. Next cycle r0req with r0ad=0x10 → r0ack same cycle, r0vld one cycle later with rdo=0x1A5, r1vld stays 0.
- DEL=2, r0req and r1req both held high for 6 cycles, r0ad=3 and r1ad=4 (with 3 and 4 previously written) → acks alternate r0,r1,r0,r1,r0,r1; valids alternate two cycles later with matching data.
- Write 0x0FF and read address 7 in the same cycle, old value 0x011 → rdo=0x011. A read the following cycle returns 0x0FF.
- init_req pulsed while r1 has a grant in flight (DEL=2) → r1vld still fires. The next cycle shows wen=1, wad=0, wda=0, init_done=0; cwen is ignored and r0req gets no ack for 256 cycles.
- rst asserted mid-INIT at cnt=100 → outputs return to reset values asynchronously. After release, INIT restarts at wad=0.
